sprite_playfield_mixer: RTL and testbench

Pixel-stage mixer directly downstream of the sprite scanline renderer. It merges the renderer's 4-bit sprite colour with a 4-bit playfield colour under a priority bit and produces the final registered RGB. It also gathers per-frame sprite-vs-playfield collision statistics that the FEMTO-16 CPU reads through a clear-on-read port.

---
 rtl/sprite_playfield_mixer.sv | 170 +++++++++++++++++
 tb/tb_sprite_playfield_mixer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_playfield_mixer.sv
// -----------------------------------------------------------------------------
// sprite_playfield_mixer
//
// Pixel-stage mixer behind the sprite scanline renderer. Merges the renderer's
// 4-bit sprite colour with a 4-bit playfield colour under a priority bit to
// form the registered output pixel, and accumulates per-frame sprite-vs-
// playfield collision statistics. The CPU reads the statistics through a
// clear-on-read port.
//
// Optional feature macro: SPRITE_COLLIDE_IRQ_EN
//   defined   : irq is a flop, set by a snapshot with a non-zero mask and
//               cleared on the edge after coll_rd.
//   undefined : irq is tied to 0. The port is kept.
//
// Parameters
//   PF_DELAY     alignment stages on pf_rgb/pf_priority/display_on (0..3)
//   SNAP_LINE    vpos at which the frame snapshot is taken (with hpos == 0)
//
// Ports
//   clk          pixel clock
//   reset        asynchronous, active-high reset
//   hpos, vpos   beam position from the hvsync generator
//   display_on   visible-area flag
//   sprite_rgb   sprite colour, 0 = transparent (already aligned)
//   pf_rgb       playfield colour, 0 = background
//   pf_priority  1: a non-zero playfield pixel wins over a sprite
//   rgb          final pixel colour (registered)
//   coll_rd      single-cycle CPU read strobe (clear-on-read)
//   coll_mask    snapshot mask; bit c set if sprite colour c collided
//   coll_count   snapshot count of colliding pixels, saturating at 255
//   frame_strobe one-cycle pulse when a snapshot is taken
//   irq          collision interrupt
// -----------------------------------------------------------------------------
module sprite_playfield_mixer #(
  parameter int unsigned PF_DELAY  = 1,
  parameter int unsigned SNAP_LINE = 256,
  localparam int unsigned POS_W  = 9,
  localparam int unsigned COL_W  = 4,
  localparam int unsigned MASK_W = 16,
  localparam int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  input  logic              display_on,
  input  logic [COL_W-1:0]  sprite_rgb,
  input  logic [COL_W-1:0]  pf_rgb,
  input  logic              pf_priority,
  output logic [COL_W-1:0]  rgb,
  input  logic              coll_rd,
  output logic [MASK_W-1:0] coll_mask,
  output logic [CNT_W-1:0]  coll_count,
  output logic              frame_strobe,
  output logic              irq
);

  localparam int unsigned DLY_W = COL_W + 2;

  logic [DLY_W-1:0]  dly_in_c;
  logic [DLY_W-1:0]  dly_out_c;
  logic [COL_W-1:0]  pfd_c;
  logic              prid_c;
  logic              dond_c;
  logic              collide_c;
  logic              snap_c;
  logic [MASK_W-1:0] coll_bit_c;

  logic [MASK_W-1:0] live_mask;
  logic [CNT_W-1:0]  live_count;

  assign dly_in_c = {display_on, pf_priority, pf_rgb};

  // Playfield alignment delay line; depth 0 is a straight wire.
  generate
    if (PF_DELAY == 0) begin : g_no_delay
      assign dly_out_c = dly_in_c;
    end else begin : g_delay
      logic [DLY_W-1:0] pipe [PF_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(PF_DELAY); i++) begin
            pipe[i] <= '0;
          end
        end else begin
          pipe[0] <= dly_in_c;
          for (int i = 1; i < int'(PF_DELAY); i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign dly_out_c = pipe[PF_DELAY-1];
    end
  endgenerate

  assign pfd_c  = dly_out_c[COL_W-1:0];
  assign prid_c = dly_out_c[COL_W];
  assign dond_c = dly_out_c[COL_W+1];

  // Priority is deliberately ignored for collision detection.
  assign collide_c  = dond_c && (sprite_rgb != '0) && (pfd_c != '0);
  assign snap_c     = (vpos == POS_W'(SNAP_LINE)) && (hpos == '0);
  assign coll_bit_c = MASK_W'(1) << sprite_rgb;

  // Registered pixel mix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb <= '0;
    end else if (!dond_c) begin
      rgb <= '0;
    end else if ((sprite_rgb != '0) && (!prid_c || (pfd_c == '0))) begin
      rgb <= sprite_rgb;
    end else begin
      rgb <= pfd_c;
    end
  end

  // Live collision accumulation; a collision on the snapshot cycle seeds the
  // freshly cleared set for the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_mask  <= '0;
      live_count <= '0;
    end else if (snap_c) begin
      live_mask  <= collide_c ? coll_bit_c : '0;
      live_count <= collide_c ? CNT_W'(1) : '0;
    end else if (collide_c) begin
      live_mask <= live_mask | coll_bit_c;
      if (live_count != '1) begin
        live_count <= live_count + CNT_W'(1);
      end
    end
  end

  // Snapshot registers; a snapshot beats a simultaneous read-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_mask    <= '0;
      coll_count   <= '0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= snap_c;
      if (snap_c) begin
        coll_mask  <= live_mask;
        coll_count <= live_count;
      end else if (coll_rd) begin
        coll_mask  <= '0;
        coll_count <= '0;
      end
    end
  end

`ifdef SPRITE_COLLIDE_IRQ_EN
  // Collision interrupt; setting by snapshot beats the read-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (snap_c && (live_mask != '0)) begin
      irq <= 1'b1;
    end else if (coll_rd) begin
      irq <= 1'b0;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_playfield_mixer.sv
// -----------------------------------------------------------------------------
// tb_sprite_playfield_mixer
//
// Directed-vector bench for sprite_playfield_mixer. Two instances share the
// stimulus: u_dut0 (PF_DELAY = 0) carries mix, collision, snapshot, read and
// reset checks; u_dut2 (PF_DELAY = 2) carries the alignment check.
// irq expectations follow SPRITE_COLLIDE_IRQ_EN as defined for this build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_playfield_mixer;

`ifdef SPRITE_COLLIDE_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic [3:0]  sprite_rgb;
  logic [3:0]  pf_rgb;
  logic        pf_priority;
  logic        coll_rd;

  logic [3:0]  rgb0, rgb2;
  logic [15:0] mask0, mask2;
  logic [7:0]  count0, count2;
  logic        strobe0, strobe2;
  logic        irq0, irq2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sprite_playfield_mixer #(.PF_DELAY(0), .SNAP_LINE(256)) u_dut0 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .sprite_rgb(sprite_rgb), .pf_rgb(pf_rgb),
    .pf_priority(pf_priority), .rgb(rgb0), .coll_rd(coll_rd),
    .coll_mask(mask0), .coll_count(count0), .frame_strobe(strobe0), .irq(irq0)
  );

  sprite_playfield_mixer #(.PF_DELAY(2), .SNAP_LINE(256)) u_dut2 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .sprite_rgb(sprite_rgb), .pf_rgb(pf_rgb),
    .pf_priority(pf_priority), .rgb(rgb2), .coll_rd(coll_rd),
    .coll_mask(mask2), .coll_count(count2), .frame_strobe(strobe2), .irq(irq2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] spr, input logic [3:0] pf,
                       input logic pri, input logic don);
    sprite_rgb  = spr;
    pf_rgb      = pf;
    pf_priority = pri;
    display_on  = don;
  endtask

  task automatic collide(input logic [3:0] colour, input int n);
    for (int i = 0; i < n; i++) begin
      drive(colour, 4'd1, 1'b0, 1'b1);
      tick();
    end
    drive(4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  // One snapshot cycle; returns with position back in mid-frame.
  task automatic snap(input logic rd);
    vpos = 9'd256;
    hpos = 9'd0;
    coll_rd = rd;
    tick();
    vpos = 9'd10;
    hpos = 9'd5;
    coll_rd = 1'b0;
  endtask

  task automatic check_snap(input string tag, input logic [15:0] m,
                            input logic [7:0] c, input logic irq_set);
    check({tag, "_strobe"}, 16'(strobe0), 16'd1);
    check({tag, "_mask"},   mask0, m);
    check({tag, "_count"},  16'(count0), 16'(c));
    check({tag, "_irq"},    16'(irq0), 16'(irq_set & IRQ_EN));
  endtask

  // Read pulse: values hold during the strobe cycle, then clear.
  task automatic read_clear(input string tag, input logic [15:0] m, input logic [7:0] c);
    coll_rd = 1'b1;
    #1;
    check({tag, "_hold_mask"},  mask0, m);
    check({tag, "_hold_count"}, 16'(count0), 16'(c));
    tick();
    coll_rd = 1'b0;
    check({tag, "_clr_mask"},  mask0, 16'd0);
    check({tag, "_clr_count"}, 16'(count0), 16'd0);
    check({tag, "_clr_irq"},   16'(irq0), 16'd0);
  endtask

  initial begin
    reset = 1'b1;
    hpos = 9'd5;
    vpos = 9'd10;
    coll_rd = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_rgb0",   16'(rgb0), 16'd0);
    check("rst_mask0",  mask0, 16'd0);
    check("rst_count0", 16'(count0), 16'd0);
    check("rst_strobe", 16'(strobe0), 16'd0);
    check("rst_irq0",   16'(irq0), 16'd0);
    check("rst_dut2",   {rgb2, 4'(count2), 3'd0, strobe2, 3'd0, irq2} | mask2, 16'd0);
    reset = 1'b0;

    // Priority mix, PF_DELAY = 0.
    drive(4'd5, 4'd0, 1'b0, 1'b1); tick(); check("mix_spr_over_bg",  16'(rgb0), 16'd5);
    drive(4'd5, 4'd3, 1'b0, 1'b1); tick(); check("mix_spr_pri0",     16'(rgb0), 16'd5);
    drive(4'd5, 4'd3, 1'b1, 1'b1); tick(); check("mix_pf_pri1",      16'(rgb0), 16'd3);
    drive(4'd5, 4'd3, 1'b1, 1'b0); tick(); check("mix_blank",        16'(rgb0), 16'd0);
    drive(4'd0, 4'd6, 1'b0, 1'b1); tick(); check("mix_pf_only",      16'(rgb0), 16'd6);
    drive(4'd5, 4'd0, 1'b1, 1'b1); tick(); check("mix_pri1_bg",      16'(rgb0), 16'd5);

    // Near-miss snapshot positions must not fire.
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    vpos = 9'd256; hpos = 9'd1; tick(); check("nosnap_h1", 16'(strobe0), 16'd0);
    vpos = 9'd0;   hpos = 9'd0; tick(); check("nosnap_v0", 16'(strobe0), 16'd0);
    vpos = 9'd10;  hpos = 9'd5;

    // Two colour-5 collisions happened in the mix checks above.
    snap(1'b0);
    check_snap("snap_mix", 16'h0020, 8'd2, 1'b1);
    tick();
    check("strobe_one_cycle", 16'(strobe0), 16'd0);
    read_clear("rd_mix", 16'h0020, 8'd2);

    // Alignment, PF_DELAY = 2: pulse at t appears at t+3.
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    tick(); tick(); tick();
    pf_rgb = 4'd7;
    tick();
    pf_rgb = 4'd0;
    check("align0_t1", 16'(rgb0), 16'd7);
    check("align2_t1", 16'(rgb2), 16'd0);
    tick(); check("align2_t2", 16'(rgb2), 16'd0);
    tick(); check("align2_t3", 16'(rgb2), 16'd7);
    tick(); check("align2_t4", 16'(rgb2), 16'd0);

    // Frame A: three colour-2 and one colour-9 collision plus non-collisions.
    drive(4'd2, 4'd1, 1'b0, 1'b1); tick();
    drive(4'd2, 4'd4, 1'b1, 1'b1); tick(); check("coll_pri_rgb", 16'(rgb0), 16'd4);
    drive(4'd2, 4'd3, 1'b0, 1'b1); tick();
    drive(4'd9, 4'd2, 1'b0, 1'b1); tick();
    drive(4'd9, 4'd2, 1'b0, 1'b0); tick();
    drive(4'd9, 4'd0, 1'b0, 1'b1); tick();
    drive(4'd0, 4'd5, 1'b0, 1'b1); tick();
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    snap(1'b0);
    check_snap("snap_a", 16'h0204, 8'd4, 1'b1);
    check("snap_a_strobe2", 16'(strobe2), 16'd1);
    read_clear("rd_a", 16'h0204, 8'd4);

    // Frame B: nothing collides except on the snapshot cycle itself.
    tick();
    drive(4'd9, 4'd1, 1'b0, 1'b1);
    snap(1'b0);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    check_snap("snap_b", 16'h0000, 8'd0, 1'b0);

    // Frame C: carries only the snapshot-cycle collision.
    tick();
    snap(1'b0);
    check_snap("snap_c", 16'h0200, 8'd1, 1'b1);
    read_clear("rd_c", 16'h0200, 8'd1);

    // Saturation; read coinciding with the snapshot keeps the new values.
    collide(4'd15, 300);
    snap(1'b1);
    check_snap("snap_sat", 16'h8000, 8'd255, 1'b1);
    tick();
    check("sat_kept_mask",  mask0, 16'h8000);
    check("sat_kept_count", 16'(count0), 16'd255);
    read_clear("rd_sat", 16'h8000, 8'd255);

    // Async reset mid-frame.
    collide(4'd3, 2);
    snap(1'b0);
    check_snap("snap_pre_rst", 16'h0008, 8'd2, 1'b1);
    collide(4'd4, 2);
    drive(4'd4, 4'd0, 1'b0, 1'b1);
    tick();
    check("pre_rst_rgb", 16'(rgb0), 16'd4);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rgb",    16'(rgb0), 16'd0);
    check("arst_mask",   mask0, 16'd0);
    check("arst_count",  16'(count0), 16'd0);
    check("arst_strobe", 16'(strobe0), 16'd0);
    check("arst_irq",    16'(irq0), 16'd0);
    drive(4'd0, 4'd0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    collide(4'd6, 1);
    snap(1'b0);
    check_snap("snap_post_rst", 16'h0040, 8'd1, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
